uop_bundle_queue: RTL and testbench
===================================

Name: uop_bundle_queue

Overview:
Decoupling queue between the instruction decoder and the reservation station.
- Decoder pushes bundles of up to three 20-bit uops, plus a uop count and a 16-bit immediate (k16).
- The queue presents the head bundle to the reservation station and pops it when the station raises its feed request.
- This is the transmitter end of the station's id_* feed interface. It absorbs decoder bursts and supports pipeline flush.

Parameters:
- DEPTH, 4: number of bundle entries; power of two, minimum 2.
- ADDR_W, 2: log2(DEPTH).
- UOP_W, 20: uop width.
- NOP, 20'h00F00: filler uop (0000_0000_1111_00_000_000) for unused slots and the empty queue.

Ports:
- clk  in  1  clock; all state on rising edge.
- a_rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous queue clear (branch redirect / interrupt).
- dec_valid  in  1  decoder offers a bundle.
- dec_ready  out  1  queue can accept a bundle this cycle.
- dec_uop_0/1/2  in  20 each  decoded uops; slot 0 executes first.
- dec_uop_count  in  2  valid uops in the bundle (0..3).
- dec_k16  in  16  immediate/operand associated with the bundle.
- rs_feed_req  in  1  station is empty and samples the id_* bus at this edge.
- id_uop_0/1/2  out  20 each  head bundle uops to the station.
- id_uop_count  out  2  head bundle count; 0 when the queue is empty.
- id_k16  out  16  head bundle immediate.
- q_level  out  ADDR_W+1  occupied entries, 0..DEPTH.
- q_empty  out  1  q_level == 0.
- q_full  out  1  q_level == DEPTH.

Behaviour:
- Reset (a_rst low, any time, including mid-burst):
  - wr_ptr = rd_ptr = 0, level = 0.
  - Outputs: q_empty = 1, q_full = 0, dec_ready = 1, id_uop_* = NOP, id_uop_count = 0, id_k16 = 0.
  - Entry storage needs no reset.
- dec_ready = ~q_full. It depends only on registered state; there is no combinational path from rs_feed_req.
- Push condition: dec_valid & dec_ready & (dec_uop_count != 0) & ~flush.
  - Writes to entry[wr_ptr]; wr_ptr increments modulo DEPTH.
  - A bundle offered with count 0 is accepted (the handshake completes) but not stored.
- Slot masking on write: any slot index >= dec_uop_count is stored as NOP. Example: count 1 stores {uop_0, NOP, NOP}.
- Pop condition: rs_feed_req & ~q_empty & ~flush. rd_ptr increments modulo DEPTH. The station captures the head at the same edge, so the outputs must be valid before the edge.
- Read-side outputs are combinational from entry[rd_ptr] when non-empty. When empty they are forced to NOP / count 0 / k16 0. rs_feed_req while empty is legal and pops nothing.
- No empty bypass: a pushed bundle is visible at the earliest one cycle after the push edge.
- Level update:
  - +1 on push only, -1 on pop only.
  - Unchanged when push and pop occur together. This is legal at any level 1..DEPTH-1; it cannot occur at full because dec_ready = 0.
- Flush dominates:
  - Pointers and level go to 0 at that edge.
  - A simultaneous push is discarded and a simultaneous pop has no effect.
  - The next cycle shows the empty outputs.
- Pointers are ADDR_W bits and wrap naturally. Full/empty are derived from level, not from pointer comparison.
- Ordering: strict FIFO; bundle contents are never reordered or merged.
- Assertions (verification):
  - level <= DEPTH.
  - No push while q_full.
  - id_uop_count != 0 whenever ~q_empty.

Decomposition:
- Shared core definitions include: UOP_W, NOP uop constant, uop-count width. The reservation station uses the same NOP value.
- One sub-module: bundle_fifo_ctrl, which holds the pointers, level, full/empty, push/pop/flush arbitration. It is parameterised by DEPTH/ADDR_W.
- The top level holds the storage array, slot masking and output muxing.

Test Plan:
- Reset: a_rst low -> id_uop_0/1/2 = 20'h00F00, id_uop_count = 0, id_k16 = 0, dec_ready = 1, q_empty = 1, q_level = 0.
- Single push: bundle {A=20'h12345, B=20'h0ABCD, C=20'h55555}, count 2, k16 16'h1234, rs_feed_req = 0 -> next cycle id_uop_0 = 12345, id_uop_1 = 0ABCD, id_uop_2 = 00F00, id_uop_count = 2, id_k16 = 1234, q_level = 1.
- Fill and backpressure: push 4 bundles -> q_full = 1, dec_ready = 0, a 5th held bundle is not stored. One-cycle rs_feed_req -> head popped, next cycle dec_ready = 1, 5th accepted, q_level = 4 again.
- Simultaneous push and pop at level 2 -> q_level stays 2. Pop order over 10 push/pop cycles matches push order across pointer wrap.
- Flush with dec_valid and rs_feed_req both high at level 3 -> next cycle q_level = 0, id_uop_count = 0, outputs NOP. The concurrent bundle is never presented.
- Count-0 bundle with dec_valid = 1 -> dec_ready = 1, q_level unchanged, the bundle is never presented. Asynchronous reset asserted mid-burst at level 3 -> immediate empty outputs.

Source files
------------

// File: rtl/uop_bundle_queue_pkg.sv
// Shared uop definitions for the decoder/reservation-station path.
// The station relies on the same NOP encoding for empty slots.
package uop_bundle_queue_pkg;

  localparam int UOP_W = 20;
  localparam int CNT_W = 2;
  localparam int K16_W = 16;

  localparam logic [UOP_W-1:0] NOP = 20'h00F00;

  typedef struct packed {
    logic [UOP_W-1:0] uop_2;
    logic [UOP_W-1:0] uop_1;
    logic [UOP_W-1:0] uop_0;
    logic [CNT_W-1:0] count;
    logic [K16_W-1:0] k16;
  } bundle_t;

  // Slots at or beyond the bundle's uop count are stored as NOP.
  function automatic logic [UOP_W-1:0] mask_slot(input logic [UOP_W-1:0] uop,
                                                  input logic [CNT_W-1:0] slot,
                                                  input logic [CNT_W-1:0] count);
    return (slot < count) ? uop : NOP;
  endfunction

endpackage

// File: rtl/uop_bundle_queue_bundle_fifo_ctrl.sv
// Pointer/level bookkeeping for the bundle queue.
// Full and empty come from the level count, so the pointers are free to wrap.
module bundle_fifo_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              flush,
  input  logic              push_req,
  input  logic              pop_req,
  output logic              push,
  output logic              pop,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);

  // Flush suppresses both handshakes so nothing is stored or consumed on that edge.
  assign push = push_req & ~full & ~flush;
  assign pop  = pop_req & ~empty & ~flush;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  a_level_bound: assert property (@(posedge clk) disable iff (!a_rst) level <= FULL_LVL);
  a_no_push_full: assert property (@(posedge clk) disable iff (!a_rst) full |-> !push);

endmodule

// File: rtl/uop_bundle_queue.sv
// Decoupling queue from the decoder to the reservation station's id_* feed.
// The head bundle is driven combinationally so the station can sample it on its feed edge.
module uop_bundle_queue
  import uop_bundle_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [UOP_W-1:0]  dec_uop_0,
  input  logic [UOP_W-1:0]  dec_uop_1,
  input  logic [UOP_W-1:0]  dec_uop_2,
  input  logic [CNT_W-1:0]  dec_uop_count,
  input  logic [K16_W-1:0]  dec_k16,
  input  logic              rs_feed_req,
  output logic [UOP_W-1:0]  id_uop_0,
  output logic [UOP_W-1:0]  id_uop_1,
  output logic [UOP_W-1:0]  id_uop_2,
  output logic [CNT_W-1:0]  id_uop_count,
  output logic [K16_W-1:0]  id_k16,
  output logic [ADDR_W:0]   q_level,
  output logic              q_empty,
  output logic              q_full
);

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  bundle_t           entries [DEPTH];
  bundle_t           wr_bundle;
  bundle_t           head;

  bundle_fifo_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk      (clk),
    .a_rst    (a_rst),
    .flush    (flush),
    .push_req (dec_valid & (dec_uop_count != '0)),
    .pop_req  (rs_feed_req),
    .push     (push),
    .pop      (pop),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .level    (q_level),
    .empty    (q_empty),
    .full     (q_full)
  );

  // A count-0 bundle still completes the handshake; it just never reaches storage.
  assign dec_ready = ~q_full;

  always_comb begin
    wr_bundle.uop_0 = mask_slot(dec_uop_0, CNT_W'(0), dec_uop_count);
    wr_bundle.uop_1 = mask_slot(dec_uop_1, CNT_W'(1), dec_uop_count);
    wr_bundle.uop_2 = mask_slot(dec_uop_2, CNT_W'(2), dec_uop_count);
    wr_bundle.count = dec_uop_count;
    wr_bundle.k16   = dec_k16;
  end

  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= wr_bundle;
  end

  assign head = entries[rd_ptr];

  // Storage is unreset, so the empty case must override whatever the array holds.
  always_comb begin
    id_uop_0     = NOP;
    id_uop_1     = NOP;
    id_uop_2     = NOP;
    id_uop_count = '0;
    id_k16       = '0;
    if (!q_empty) begin
      id_uop_0     = head.uop_0;
      id_uop_1     = head.uop_1;
      id_uop_2     = head.uop_2;
      id_uop_count = head.count;
      id_k16       = head.k16;
    end
  end

  a_head_count: assert property (@(posedge clk) disable iff (!a_rst) !q_empty |-> id_uop_count != '0);

endmodule

// File: tb/tb_uop_bundle_queue.sv
// Directed self-checking bench for uop_bundle_queue.
// Inputs change 1ns after each rising edge; outputs are checked in the same window.
module tb_uop_bundle_queue;

  localparam logic [19:0] NOP = 20'h00F00;

  logic        clk;
  logic        a_rst;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [19:0] dec_uop_0, dec_uop_1, dec_uop_2;
  logic [1:0]  dec_uop_count;
  logic [15:0] dec_k16;
  logic        rs_feed_req;
  logic [19:0] id_uop_0, id_uop_1, id_uop_2;
  logic [1:0]  id_uop_count;
  logic [15:0] id_k16;
  logic [2:0]  q_level;
  logic        q_empty;
  logic        q_full;

  int checks = 0;
  int errors = 0;

  uop_bundle_queue #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk           (clk),
    .a_rst         (a_rst),
    .flush         (flush),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_uop_0     (dec_uop_0),
    .dec_uop_1     (dec_uop_1),
    .dec_uop_2     (dec_uop_2),
    .dec_uop_count (dec_uop_count),
    .dec_k16       (dec_k16),
    .rs_feed_req   (rs_feed_req),
    .id_uop_0      (id_uop_0),
    .id_uop_1      (id_uop_1),
    .id_uop_2      (id_uop_2),
    .id_uop_count  (id_uop_count),
    .id_k16        (id_k16),
    .q_level       (q_level),
    .q_empty       (q_empty),
    .q_full        (q_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [19:0] u0, input logic [19:0] u1,
                               input logic [19:0] u2, input logic [1:0] cnt, input logic [15:0] k,
                               input logic feed, input logic fl);
    dec_valid     = valid;
    dec_uop_0     = u0;
    dec_uop_1     = u1;
    dec_uop_2     = u2;
    dec_uop_count = cnt;
    dec_k16       = k;
    rs_feed_req   = feed;
    flush         = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 20'h0, 20'h0, 20'h0, 2'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [19:0] u0, input logic [19:0] u1,
                           input logic [19:0] u2, input logic [1:0] cnt, input logic [15:0] k);
    checkOutput({tag, ".uop0"}, 32'(id_uop_0), 32'(u0));
    checkOutput({tag, ".uop1"}, 32'(id_uop_1), 32'(u1));
    checkOutput({tag, ".uop2"}, 32'(id_uop_2), 32'(u2));
    checkOutput({tag, ".count"}, 32'(id_uop_count), 32'(cnt));
    checkOutput({tag, ".k16"}, 32'(id_k16), 32'(k));
  endtask

  task automatic checkEmpty(input string tag);
    checkHead(tag, NOP, NOP, NOP, 2'd0, 16'h0);
    checkOutput({tag, ".level"}, 32'(q_level), 32'd0);
    checkOutput({tag, ".empty"}, 32'(q_empty), 32'd1);
    checkOutput({tag, ".ready"}, 32'(dec_ready), 32'd1);
  endtask

  // Wrap-test bundle idx: uops 4xxxx/5xxxx/6xxxx, count cycles 1,2,3.
  function automatic logic [1:0] cntFor(input int idx);
    return 2'((idx % 3) + 1);
  endfunction

  function automatic logic [19:0] slotVal(input logic [19:0] v, input int slot, input logic [1:0] cnt);
    return (slot < int'(cnt)) ? v : NOP;
  endfunction

  task automatic driveIdx(input int idx, input logic feed);
    applyStimulus(1'b1, 20'h40000 + 20'(idx), 20'h50000 + 20'(idx), 20'h60000 + 20'(idx),
                  cntFor(idx), 16'(idx), feed, 1'b0);
  endtask

  task automatic checkIdx(input int idx);
    logic [1:0] c;
    c = cntFor(idx);
    checkHead($sformatf("wrap_head%0d", idx), 20'h40000 + 20'(idx),
              slotVal(20'h50000 + 20'(idx), 1, c), slotVal(20'h60000 + 20'(idx), 2, c), c, 16'(idx));
  endtask

  initial begin
    idle();
    a_rst = 1'b1;
    #1 a_rst = 1'b0;
    step();
    step();
    checkEmpty("reset");
    checkOutput("reset.full", 32'(q_full), 32'd0);
    a_rst = 1'b1;
    step();

    // Single push with count 2; not visible until after the edge.
    applyStimulus(1'b1, 20'h12345, 20'h0ABCD, 20'h55555, 2'd2, 16'h1234, 1'b0, 1'b0);
    #1;
    checkOutput("nobypass.count", 32'(id_uop_count), 32'd0);
    step();
    idle();
    checkHead("single", 20'h12345, 20'h0ABCD, NOP, 2'd2, 16'h1234);
    checkOutput("single.level", 32'(q_level), 32'd1);
    rs_feed_req = 1'b1;
    step();
    idle();
    checkEmpty("single_pop");

    // Fill to full, then hold a fifth bundle under backpressure.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 20'h10000 + 20'(i), 20'h20000 + 20'(i), 20'h30000 + 20'(i), 2'd3, 16'(i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 20'h10004, 20'h20004, 20'h30004, 2'd3, 16'd4, 1'b0, 1'b0);
    checkOutput("fill.full", 32'(q_full), 32'd1);
    checkOutput("fill.ready", 32'(dec_ready), 32'd0);
    checkOutput("fill.level", 32'(q_level), 32'd4);
    step();
    checkOutput("held.level", 32'(q_level), 32'd4);
    checkHead("held.head", 20'h10000, 20'h20000, 20'h30000, 2'd3, 16'd0);
    rs_feed_req = 1'b1;
    step();
    rs_feed_req = 1'b0;
    checkOutput("afterpop.ready", 32'(dec_ready), 32'd1);
    checkOutput("afterpop.level", 32'(q_level), 32'd3);
    step();
    idle();
    checkOutput("refill.level", 32'(q_level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      checkHead($sformatf("drain%0d", i), 20'h10000 + 20'(i), 20'h20000 + 20'(i),
                20'h30000 + 20'(i), 2'd3, 16'(i));
      rs_feed_req = 1'b1;
      step();
    end
    idle();
    checkEmpty("drained");

    // Push/pop together at level 2 across several pointer wraps.
    driveIdx(0, 1'b0);
    step();
    driveIdx(1, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      checkIdx(k);
      driveIdx(k + 2, 1'b1);
      step();
      checkOutput($sformatf("wrap_level%0d", k), 32'(q_level), 32'd2);
    end
    idle();
    for (int k = 10; k < 12; k++) begin
      checkIdx(k);
      rs_feed_req = 1'b1;
      step();
    end
    idle();
    checkEmpty("wrap_end");

    // Flush at level 3 with a concurrent push and pop.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 20'h70000 + 20'(i), 20'h0, 20'h0, 2'd1, 16'(i), 1'b0, 1'b0);
      step();
    end
    checkOutput("preflush.level", 32'(q_level), 32'd3);
    applyStimulus(1'b1, 20'h77777, 20'h77777, 20'h77777, 2'd3, 16'h7777, 1'b1, 1'b1);
    step();
    idle();
    checkEmpty("flush");
    step();
    checkEmpty("flush_after");

    // Count-0 bundle completes the handshake but is never stored.
    applyStimulus(1'b1, 20'h99999, 20'h99999, 20'h99999, 2'd0, 16'h9999, 1'b0, 1'b0);
    #1;
    checkOutput("cnt0.ready", 32'(dec_ready), 32'd1);
    step();
    idle();
    checkEmpty("cnt0");

    // Asynchronous reset mid-cycle at level 3.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 20'h80000 + 20'(i), 20'h0, 20'h0, 2'd1, 16'(i), 1'b0, 1'b0);
      step();
    end
    checkOutput("prerst.level", 32'(q_level), 32'd3);
    #3 a_rst = 1'b0;
    #1;
    checkEmpty("async_rst");
    idle();
    step();
    a_rst = 1'b1;
    step();
    checkEmpty("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
